// File: rtl/auth_engine.sv
// auth_engine: sequential account/PIN table lookup, one entry per cycle, with
// per-account failed-attempt lockout and a single tracked session.
module auth_engine #(
  parameter int NUM_ACC   = 4,
  parameter int ACC_W     = 4,
  parameter int PIN_W     = 4,
  parameter int MAX_TRIES = 3,
  parameter int IDX_W     = $clog2(NUM_ACC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             action,
  input  logic [ACC_W-1:0] acc_number,
  input  logic [PIN_W-1:0] pin,
  input  logic             deAuth,
  input  logic             unlock_valid,
  input  logic [IDX_W-1:0] unlock_index,
  output logic             done,
  output logic             wasSuccessful,
  output logic             locked_out,
  output logic [IDX_W-1:0] accIndex,
  output logic             session_active,
  output logic [IDX_W-1:0] session_index
);

  localparam int               CNT_W    = $clog2(MAX_TRIES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_TRIES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ACC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDX_W-1:0] scan_idx_r;
  logic             action_r;
  logic [ACC_W-1:0] acc_r;
  logic [PIN_W-1:0] pin_r;
  logic [CNT_W-1:0] fail_cnt_r [NUM_ACC];

  logic             ready_r;
  logic             done_r;
  logic             succ_r;
  logic             locked_r;
  logic [IDX_W-1:0] idx_r;
  logic             sess_act_r;
  logic [IDX_W-1:0] sess_idx_r;

  logic               acc_hit_s;
  logic               last_s;
  logic               finish_s;
  logic               cur_locked_s;
  logic               pin_ok_s;
  logic               res_succ_s;
  logic               res_locked_s;
  logic [IDX_W-1:0]   res_idx_s;
  logic               cnt_inc_s;
  logic               cnt_clr_s;
  logic               sess_set_s;
  logic [NUM_ACC-1:0] unlock_hit_s;

  // The table is fixed (entry i holds account i and PIN i), so it is computed, not stored.
  function automatic logic [ACC_W-1:0] table_acc(input logic [IDX_W-1:0] k);
    table_acc = ACC_W'(k);
  endfunction

  function automatic logic [PIN_W-1:0] table_pin(input logic [IDX_W-1:0] k);
    table_pin = PIN_W'(k);
  endfunction

  // Compare the entry under the scan pointer against the latched request.
  always_comb begin
    acc_hit_s    = (state_r == SCAN) && (table_acc(scan_idx_r) == acc_r);
    last_s       = (scan_idx_r == IDX_LAST);
    finish_s     = (state_r == SCAN) && (acc_hit_s || last_s);
    cur_locked_s = (fail_cnt_r[scan_idx_r] == CNT_MAX);
    pin_ok_s     = (table_pin(scan_idx_r) == pin_r);
  end

  // Decode the outcome of a hit; a miss leaves every result field at zero.
  always_comb begin
    res_succ_s   = 1'b0;
    res_locked_s = 1'b0;
    res_idx_s    = {IDX_W{1'b0}};
    cnt_inc_s    = 1'b0;
    cnt_clr_s    = 1'b0;
    sess_set_s   = 1'b0;
    if (acc_hit_s) begin
      res_idx_s = scan_idx_r;
      if (!action_r) begin
        res_succ_s   = 1'b1;
        res_locked_s = cur_locked_s;
      end else if (cur_locked_s) begin
        res_locked_s = 1'b1;
      end else if (pin_ok_s) begin
        res_succ_s = 1'b1;
        cnt_clr_s  = 1'b1;
        sess_set_s = 1'b1;
      end else begin
        cnt_inc_s = 1'b1;
      end
    end else begin
      res_idx_s = {IDX_W{1'b0}};
    end
  end

  // One-hot unlock select; indices beyond the table never match any entry.
  always_comb begin
    unlock_hit_s = {NUM_ACC{1'b0}};
    for (int i = 0; i < NUM_ACC; i++) begin
      unlock_hit_s[i] = unlock_valid && (unlock_index == IDX_W'(i));
    end
  end

  // Next-state logic for IDLE -> SCAN -> RESP -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (finish_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register, handshake flags, scan pointer and request latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      scan_idx_r <= {IDX_W{1'b0}};
      action_r   <= 1'b0;
      acc_r      <= {ACC_W{1'b0}};
      pin_r      <= {PIN_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == IDLE);
      done_r  <= finish_s;
      if ((state_r == IDLE) && req_valid) begin
        scan_idx_r <= {IDX_W{1'b0}};
        action_r   <= action;
        acc_r      <= acc_number;
        pin_r      <= pin;
      end else if ((state_r == SCAN) && !finish_s) begin
        scan_idx_r <= scan_idx_r + IDX_W'(1);
      end
    end
  end

  // Result registers hold from one response to the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      succ_r   <= 1'b0;
      locked_r <= 1'b0;
      idx_r    <= {IDX_W{1'b0}};
    end else if (finish_s) begin
      succ_r   <= res_succ_s;
      locked_r <= res_locked_s;
      idx_r    <= res_idx_s;
    end
  end

  // Session tracking; de-authentication beats a simultaneous login.
  always_ff @(posedge clk) begin
    if (reset) begin
      sess_act_r <= 1'b0;
      sess_idx_r <= {IDX_W{1'b0}};
    end else if (deAuth) begin
      sess_act_r <= 1'b0;
      sess_idx_r <= {IDX_W{1'b0}};
    end else if (finish_s && sess_set_s) begin
      sess_act_r <= 1'b1;
      sess_idx_r <= scan_idx_r;
    end
  end

  // Fail counters; an admin unlock beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        fail_cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (unlock_hit_s[i]) begin
          fail_cnt_r[i] <= {CNT_W{1'b0}};
        end else if (cnt_clr_s && (scan_idx_r == IDX_W'(i))) begin
          fail_cnt_r[i] <= {CNT_W{1'b0}};
        end else if (cnt_inc_s && (scan_idx_r == IDX_W'(i)) && (fail_cnt_r[i] != CNT_MAX)) begin
          fail_cnt_r[i] <= fail_cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  assign req_ready      = ready_r;
  assign done           = done_r;
  assign wasSuccessful  = succ_r;
  assign locked_out     = locked_r;
  assign accIndex       = idx_r;
  assign session_active = sess_act_r;
  assign session_index  = sess_idx_r;

endmodule

// File: tb/tb_auth_engine.sv
// tb_auth_engine: directed and random requests against a table-level reference model.
module tb_auth_engine;

  localparam int NUM_ACC   = 4;
  localparam int ACC_W     = 4;
  localparam int PIN_W     = 4;
  localparam int MAX_TRIES = 3;
  localparam int IDX_W     = $clog2(NUM_ACC);

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic             action;
  logic [ACC_W-1:0] acc_number;
  logic [PIN_W-1:0] pin;
  logic             deAuth;
  logic             unlock_valid;
  logic [IDX_W-1:0] unlock_index;
  logic             done;
  logic             wasSuccessful;
  logic             locked_out;
  logic [IDX_W-1:0] accIndex;
  logic             session_active;
  logic [IDX_W-1:0] session_index;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int fail_m [NUM_ACC];
  bit sess_m;
  int sess_idx_m;

  auth_engine #(
    .NUM_ACC(NUM_ACC), .ACC_W(ACC_W), .PIN_W(PIN_W), .MAX_TRIES(MAX_TRIES), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .action(action), .acc_number(acc_number), .pin(pin), .deAuth(deAuth),
    .unlock_valid(unlock_valid), .unlock_index(unlock_index), .done(done),
    .wasSuccessful(wasSuccessful), .locked_out(locked_out), .accIndex(accIndex),
    .session_active(session_active), .session_index(session_index)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_ACC; i++) fail_m[i] = 0;
    sess_m     = 1'b0;
    sess_idx_m = 0;
  endtask

  // Issue one request, apply the table rules to the model and check the response.
  task automatic run_req(input string tag, input bit act, input int acc, input int pn,
                         input bit deauth_resp, input bit unlock_resp, input int ul_idx,
                         input bit poke);
    int k;
    int lat;
    int e_idx;
    bit e_s;
    bit e_l;
    int t;
    bit early;
    k = -1;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (k < 0 && (i % (1 << ACC_W)) == acc) k = i;
    end
    lat   = (k < 0) ? NUM_ACC : k + 1;
    e_s   = 1'b0;
    e_l   = 1'b0;
    e_idx = 0;
    if (k >= 0) begin
      e_idx = k;
      if (!act) begin
        e_s = 1'b1;
        e_l = (fail_m[k] == MAX_TRIES);
      end else if (fail_m[k] == MAX_TRIES) begin
        e_l = 1'b1;
      end else if (pn == (k % (1 << PIN_W))) begin
        e_s        = 1'b1;
        fail_m[k]  = 0;
        sess_m     = 1'b1;
        sess_idx_m = k;
      end else begin
        fail_m[k] = fail_m[k] + 1;
      end
    end
    if (deauth_resp) begin
      sess_m     = 1'b0;
      sess_idx_m = 0;
    end
    if (unlock_resp) fail_m[ul_idx] = 0;

    t = 0;
    while (!req_ready && t < 20) begin
      tick();
      t++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait: req_ready=%b required 1", tag, req_ready);
    end
    req_valid  = 1'b1;
    action     = act;
    acc_number = ACC_W'(acc);
    pin        = PIN_W'(pn);
    tick();
    req_valid  = 1'b0;
    action     = 1'($urandom);
    acc_number = ACC_W'($urandom);
    pin        = PIN_W'($urandom);
    early      = 1'b0;
    for (int n = 1; n < lat; n++) begin
      req_valid = poke && (n == 1);
      tick();
      if (done !== 1'b0 || req_ready !== 1'b0) early = 1'b1;
    end
    req_valid    = 1'b0;
    deAuth       = deauth_resp;
    unlock_valid = unlock_resp;
    unlock_index = IDX_W'(ul_idx);
    tick();
    deAuth       = 1'b0;
    unlock_valid = 1'b0;
    checks++;
    if (early || done !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: early=%0b done=%b required done only after %0d edges", tag, early, done, lat);
    end
    checks++;
    if (wasSuccessful !== e_s) begin
      errors++;
      $display("FAIL %s wasSuccessful: got %b required %b", tag, wasSuccessful, e_s);
    end
    checks++;
    if (locked_out !== e_l) begin
      errors++;
      $display("FAIL %s locked_out: got %b required %b", tag, locked_out, e_l);
    end
    checks++;
    if (accIndex !== IDX_W'(e_idx)) begin
      errors++;
      $display("FAIL %s accIndex: got %0d required %0d", tag, accIndex, e_idx);
    end
    checks++;
    if (session_active !== sess_m || session_index !== IDX_W'(sess_idx_m)) begin
      errors++;
      $display("FAIL %s session: got %b/%0d required %b/%0d", tag, session_active, session_index, sess_m, sess_idx_m);
    end
    tick();
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_resp: done=%b req_ready=%b required 0/1", tag, done, req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({req_ready, done, wasSuccessful, locked_out, accIndex, session_active, session_index}
        !== {1'b1, 1'b0, 1'b0, 1'b0, {IDX_W{1'b0}}, 1'b0, {IDX_W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_values: rdy=%b done=%b ws=%b lo=%b idx=%0d sa=%b si=%0d required 1 0 0 0 0 0 0",
               req_ready, done, wasSuccessful, locked_out, accIndex, session_active, session_index);
    end
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_auth_hit();
    run_req("auth_hit", 1'b1, 2, 2, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_find_miss();
    run_req("find_miss", 1'b0, 9, 0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_lockout();
    for (int i = 0; i < MAX_TRIES; i++) run_req("wrong_pin", 1'b1, 1, 0, 1'b0, 1'b0, 0, 1'b0);
    run_req("auth_locked", 1'b1, 1, 1, 1'b0, 1'b0, 0, 1'b0);
    run_req("find_locked", 1'b0, 1, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_unlock();
    unlock_valid = 1'b1;
    unlock_index = IDX_W'(1);
    tick();
    unlock_valid = 1'b0;
    fail_m[1]    = 0;
    run_req("auth_after_unlock", 1'b1, 1, 1, 1'b0, 1'b0, 0, 1'b0);
    run_req("find_after_unlock", 1'b0, 1, 0, 1'b0, 1'b0, 0, 1'b0);
    // Unlock on the same edge as a fail increment must leave the counter at zero.
    run_req("wrong_pin2", 1'b1, 2, 0, 1'b0, 1'b0, 0, 1'b0);
    run_req("wrong_pin2", 1'b1, 2, 0, 1'b0, 1'b0, 0, 1'b0);
    run_req("unlock_collide", 1'b1, 2, 0, 1'b0, 1'b1, 2, 1'b0);
    run_req("wrong_pin2", 1'b1, 2, 0, 1'b0, 1'b0, 0, 1'b0);
    run_req("wrong_pin2", 1'b1, 2, 0, 1'b0, 1'b0, 0, 1'b0);
    run_req("find_not_locked", 1'b0, 2, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_deauth_collision();
    run_req("session_acc0", 1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    run_req("deauth_collide", 1'b1, 3, 3, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_abort();
    bit seen;
    run_req("pre_abort_login", 1'b1, 1, 1, 1'b0, 1'b0, 0, 1'b0);
    req_valid  = 1'b1;
    action     = 1'b1;
    acc_number = ACC_W'(3);
    pin        = PIN_W'(3);
    tick();
    acc_number = ACC_W'(0);
    pin        = PIN_W'(0);
    tick();
    req_valid = 1'b0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    checks++;
    if ({req_ready, done, wasSuccessful, locked_out, accIndex, session_active, session_index}
        !== {1'b1, 1'b0, 1'b0, 1'b0, {IDX_W{1'b0}}, 1'b0, {IDX_W{1'b0}}}) begin
      errors++;
      $display("FAIL abort_values: rdy=%b done=%b ws=%b lo=%b idx=%0d sa=%b si=%0d required 1 0 0 0 0 0 0",
               req_ready, done, wasSuccessful, locked_out, accIndex, session_active, session_index);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done !== 1'b0 || req_ready !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_quiet: unexpected done or busy after abort, required idle");
    end
  endtask

  task automatic test_random();
    bit act;
    int acc;
    int pn;
    for (int n = 0; n < 40; n++) begin
      act = 1'($urandom);
      acc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(NUM_ACC, 15)) : int'($urandom_range(0, NUM_ACC - 1));
      pn  = ($urandom_range(0, 2) == 0) ? acc : int'($urandom_range(0, NUM_ACC - 1));
      run_req("random", act, acc, pn, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, NUM_ACC - 1)), 1'($urandom));
    end
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    action       = 1'b0;
    acc_number   = {ACC_W{1'b0}};
    pin          = {PIN_W{1'b0}};
    deAuth       = 1'b0;
    unlock_valid = 1'b0;
    unlock_index = {IDX_W{1'b0}};
    model_reset();
    test_reset();
    test_auth_hit();
    test_find_miss();
    test_lockout();
    test_unlock();
    test_deauth_collision();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
